// File: rtl/sim_mem_pkg.sv
// Shared constants and helpers for the multi-port simulation memory.
// Read-during-write mode encodings and a ceil-log2 for counter sizing.
package sim_mem_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v)
      r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sim_mem_port_pipe.sv
// Per-port response path: fixed-latency delay line feeding a
// fall-through response FIFO, with a credit counter gating requests.
module sim_mem_port_pipe
  import sim_mem_pkg::*;
#(
  parameter int W = 512,
  parameter int L = 50,
  parameter int D = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         acc,
  input  logic [W-1:0] din,
  input  logic         resp_ready,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [W-1:0] resp_rdata
);

  localparam int CW = clog2(D + 1);
  localparam int PW = (D > 1) ? clog2(D) : 1;
  localparam logic [CW-1:0] DMAX = CW'(D);
  localparam logic [PW-1:0] PLAST = PW'(D - 1);

  logic [L-1:0] dv;
  logic [W-1:0] dd [L];
  logic [W-1:0] fm [D];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] outst;
  logic push;
  logic pop;

  assign push       = dv[L-1];
  assign resp_valid = (cnt != '0);
  assign pop        = resp_valid & resp_ready;
  assign resp_rdata = resp_valid ? fm[rp] : '0;
  assign req_ready  = !rst && (outst < DMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv <= '0;
    end else begin
      dv[0] <= acc;
      for (int i = 1; i < L; i++)
        dv[i] <= dv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dd[0] <= din;
    for (int i = 1; i < L; i++)
      dd[i] <= dd[i-1];
  end

  always_ff @(posedge clk) begin
    if (push)
      fm[wp] <= dd[L-1];
  end

  // Credits cover delay line plus FIFO, so a push never finds it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      outst <= '0;
    end else begin
      if (push)
        wp <= (wp == PLAST) ? '0 : wp + 1'b1;
      if (pop)
        rp <= (rp == PLAST) ? '0 : rp + 1'b1;
      cnt   <= cnt + CW'(push) - CW'(pop);
      outst <= outst + CW'(acc) - CW'(pop);
    end
  end

endmodule

// File: rtl/sim_mem_mp.sv
// Multi-port simulation memory: byte-priority write arbitration,
// collision counting, read sampling and per-port response pipes.
module sim_mem_mp
  import sim_mem_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int MEM_WIDTH       = 512,
  parameter int MEM_DEPTH_LOG   = 22,
  parameter int READ_LATENCY    = 50,
  parameter int RESP_FIFO_DEPTH = 64,
  parameter int RDW_MODE        = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req_valid,
  output logic [NUM_PORTS-1:0]           req_ready,
  input  logic [NUM_PORTS*MEM_DEPTH_LOG-1:0] req_addr,
  input  logic [NUM_PORTS*MEM_WIDTH/8-1:0]   req_we,
  input  logic [NUM_PORTS*MEM_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]           resp_valid,
  input  logic [NUM_PORTS-1:0]           resp_ready,
  output logic [NUM_PORTS*MEM_WIDTH-1:0] resp_rdata,
  output logic [31:0]                    coll_count
);

  localparam int AW = MEM_DEPTH_LOG;
  localparam int BW = MEM_WIDTH / 8;
  localparam int MW = MEM_WIDTH;

  logic [MW-1:0] mem [2**AW];
  logic [NUM_PORTS-1:0] acc;
  logic coll;

  assign acc = req_valid & req_ready;

  // Descending port order: the lowest index lands last and wins.
  always_ff @(posedge clk) begin
    for (int p = NUM_PORTS - 1; p >= 0; p--)
      if (acc[p])
        for (int b = 0; b < BW; b++)
          if (req_we[p*BW + b])
            mem[req_addr[p*AW +: AW]][b*8 +: 8]
              <= req_wdata[p*MW + b*8 +: 8];
  end

  always_comb begin
    coll = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int q = p + 1; q < NUM_PORTS; q++)
        if (acc[p] && acc[q] &&
            req_addr[p*AW +: AW] == req_addr[q*AW +: AW] &&
            |(req_we[p*BW +: BW] & req_we[q*BW +: BW]))
          coll = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coll_count <= '0;
    else if (coll && coll_count != '1)
      coll_count <= coll_count + 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [MW-1:0] rdata;

    always_comb begin
      rdata = mem[req_addr[p*AW +: AW]];
      if (RDW_MODE == RDW_WRITE_FIRST)
        for (int b = 0; b < BW; b++)
          if (req_we[p*BW + b])
            rdata[b*8 +: 8] = req_wdata[p*MW + b*8 +: 8];
    end

    sim_mem_port_pipe #(
      .W(MW),
      .L(READ_LATENCY),
      .D(RESP_FIFO_DEPTH)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .acc       (acc[p]),
      .din       (rdata),
      .resp_ready(resp_ready[p]),
      .req_ready (req_ready[p]),
      .resp_valid(resp_valid[p]),
      .resp_rdata(resp_rdata[p*MW +: MW])
    );
  end

endmodule

// File: tb/tb_sim_mem_mp.sv
// Bench for sim_mem_mp: directed and random traffic on two instances
// (read-first and write-first) checked against a queue-based model.
module tb_sim_mem_mp;

  localparam int NP = 2;
  localparam int W  = 64;
  localparam int AW = 6;
  localparam int BW = 8;
  localparam int L  = 4;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] req_valid;
  logic [NP-1:0] resp_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP*BW-1:0] req_we;
  logic [NP*W-1:0] req_wdata;
  logic [NP-1:0] rr0, rr1, rv0, rv1;
  logic [NP*W-1:0] rd0, rd1;
  logic [31:0] cc0, cc1;

  always #5 clk = ~clk;

  sim_mem_mp #(
    .NUM_PORTS(NP), .MEM_WIDTH(W), .MEM_DEPTH_LOG(AW),
    .READ_LATENCY(L), .RESP_FIFO_DEPTH(D), .RDW_MODE(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rr0),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .coll_count(cc0)
  );

  sim_mem_mp #(
    .NUM_PORTS(NP), .MEM_WIDTH(W), .MEM_DEPTH_LOG(AW),
    .READ_LATENCY(L), .RESP_FIFO_DEPTH(D), .RDW_MODE(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rr1),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .coll_count(cc1)
  );

  typedef struct {
    logic [W-1:0] d;
    int t;
  } ent_t;

  ent_t q [2*NP][$];
  logic [W-1:0] mdl [2**AW];
  int outst [NP];
  int cyc, total, bad;
  logic [31:0] mcoll;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v,
                          input logic [AW-1:0] a,
                          input logic [BW-1:0] we,
                          input logic [W-1:0] wd);
    req_valid[p] = v;
    req_addr[p*AW +: AW] = a;
    req_we[p*BW +: BW] = we;
    req_wdata[p*W +: W] = wd;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we = '0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2*NP; k++)
      q[k].delete();
    for (int p = 0; p < NP; p++)
      outst[p] = 0;
    mcoll = '0;
  endtask

  // One clock: check outputs, advance model, take the edge.
  task automatic step();
    logic [NP-1:0] acc, hs, ev;
    logic [W-1:0] old [NP];
    logic [W-1:0] mrg;
    logic [AW-1:0] a;
    bit seen [int];
    bit hit;
    ent_t e;
    #1;
    for (int p = 0; p < NP; p++) begin
      ev[p] = q[p].size() > 0 && q[p][0].t <= cyc;
      chk("req_ready_rf", W'(rr0[p]), W'(outst[p] < D));
      chk("req_ready_wf", W'(rr1[p]), W'(outst[p] < D));
      chk("resp_valid_rf", W'(rv0[p]), W'(ev[p]));
      chk("resp_valid_wf", W'(rv1[p]), W'(ev[p]));
      if (ev[p]) begin
        chk("rdata_rf", rd0[p*W +: W], q[p][0].d);
        chk("rdata_wf", rd1[p*W +: W], q[NP+p][0].d);
      end
      acc[p] = req_valid[p] && outst[p] < D;
      hs[p] = ev[p] && resp_ready[p];
      old[p] = mdl[req_addr[p*AW +: AW]];
    end
    hit = 0;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        a = req_addr[p*AW +: AW];
        mrg = old[p];
        for (int b = 0; b < BW; b++)
          if (req_we[p*BW + b]) begin
            mrg[b*8 +: 8] = req_wdata[p*W + b*8 +: 8];
            if (seen.exists(int'(a) * BW + b))
              hit = 1;
            seen[int'(a) * BW + b] = 1;
          end
        e.t = cyc + 1 + L;
        e.d = old[p];
        q[p].push_back(e);
        e.d = mrg;
        q[NP+p].push_back(e);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (!acc[p]) continue;
      a = req_addr[p*AW +: AW];
      for (int b = 0; b < BW; b++) begin
        bit taken;
        taken = 0;
        for (int r = 0; r < p; r++)
          if (acc[r] && req_addr[r*AW +: AW] == a &&
              req_we[r*BW + b])
            taken = 1;
        if (req_we[p*BW + b] && !taken)
          mdl[a][b*8 +: 8] = req_wdata[p*W + b*8 +: 8];
      end
    end
    if (hit && mcoll != 32'hFFFF_FFFF)
      mcoll++;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        void'(q[p].pop_front());
        void'(q[NP+p].pop_front());
      end
      outst[p] += int'(acc[p]) - int'(hs[p]);
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("coll_rf", W'(cc0), W'(mcoll));
    chk("coll_wf", W'(cc1), W'(mcoll));
    @(negedge clk);
  endtask

  int nresp, nacc;
  logic [W-1:0] last0, last1, lastp1;

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b0;
    req_addr = '0; req_wdata = '0;
    idle();
    resp_ready = '1;
    clear_model();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", W'({rr1, rr0}), '0);
    chk("rst_resp_valid", W'({rv1, rv0}), '0);
    chk("rst_rdata", rd0[W-1:0], '0);
    chk("rst_coll", W'(cc0), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req_ready_rf", W'(rr0), W'(2'b11));
    chk("rel_req_ready_wf", W'(rr1), W'(2'b11));

    for (int i = 0; i < 2**AW / 2; i++) begin
      set_port(0, 1, AW'(2*i), '1, {$urandom, $urandom});
      set_port(1, 1, AW'(2*i+1), '1, {$urandom, $urandom});
      step();
    end
    idle();
    repeat (L + 2) step();

    set_port(0, 1, 6'h10, '1, {8{8'hA5}});
    step();
    set_port(0, 1, 6'h10, '0, '0);
    step();
    idle();
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rv0[0]) begin
        nresp++;
        last0 = rd0[W-1:0];
      end
      step();
    end
    chk("lat_count", W'(nresp), W'(2));
    chk("lat_data", last0, {8{8'hA5}});

    resp_ready = '0;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      set_port(0, 1, AW'($urandom), '0, '0);
      #1;
      if (rr0[0]) nacc++;
      step();
    end
    chk("bp_accepts", W'(nacc), W'(D));
    chk("bp_ready", W'(rr0[0]), '0);
    idle();
    resp_ready = '1;
    for (int i = 0; i < 40 && q[0].size() > 0; i++)
      step();
    chk("bp_drain", W'(q[0].size()), '0);
    #1 chk("bp_ready_back", W'(rr0[0]), W'(1));

    set_port(0, 1, 6'h20, 8'h0F, {8{8'h11}});
    set_port(1, 1, 6'h20, 8'hFF, {8{8'h22}});
    step();
    chk("coll_one", W'(cc0), W'(1));
    idle();
    set_port(0, 1, 6'h20, '0, '0);
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rv0[0]) last0 = rd0[W-1:0];
      step();
    end
    chk("coll_word", last0, 64'h22222222_11111111);

    set_port(0, 1, 6'h30, '1, '0);
    step();
    set_port(0, 1, 6'h30, '1, '1);
    set_port(1, 1, 6'h30, '0, '0);
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rv0[0]) last0 = rd0[W-1:0];
      if (rv1[0]) last1 = rd1[W-1:0];
      if (rv0[1]) lastp1 = rd0[W +: W];
      step();
    end
    chk("rdw_read_first", last0, '0);
    chk("rdw_write_first", last1, '1);
    chk("rdw_cross_port", lastp1, '0);

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, 1'($urandom), AW'($urandom_range(0, 3)),
                 $urandom_range(0, 1) ? BW'($urandom) : '0,
                 {$urandom, $urandom});
      resp_ready = NP'($urandom);
      step();
    end
    idle();
    resp_ready = '1;
    for (int i = 0; i < 60 && (q[0].size() + q[1].size()) > 0; i++)
      step();
    chk("rand_drain", W'(q[0].size() + q[1].size()), '0);

    resp_ready = '0;
    for (int i = 0; i < 5; i++) begin
      set_port(0, 1, AW'($urandom), '0, '0);
      set_port(1, 1, AW'($urandom), '0, '0);
      step();
    end
    idle();
    repeat (L + 1) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_resp_valid", W'({rv1, rv0}), '0);
    chk("arst_req_ready", W'({rr1, rr0}), '0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = '1;
    repeat (15) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
